// File: rtl/vdp_pkg.sv
// Shared VDP definitions: VRAM geometry defaults and the queued CPU
// operation record used by the VRAM port.
package vdp_pkg;

    localparam int VDP_VRAM_SIZE = 8 * 1024;
    localparam int VDP_VRAM_AW   = $clog2(VDP_VRAM_SIZE);

    typedef struct packed {
        logic                   we;
        logic [VDP_VRAM_AW-1:0] addr;
        logic [7:0]             wdata;
    } cpu_op_t;

endpackage

// File: rtl/vdp_vram_ram.sv
// Single-port synchronous VRAM, 8 bits wide. The read register only
// updates on read accesses, so it keeps the last read byte across writes.
module vdp_vram_ram #(
    parameter int DEPTH = 8 * 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          pxclk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge pxclk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/vdp_vram_port.sv
// VRAM owner: render DMA reads take every cycle they ask for, queued CPU
// ops fill the gaps in order. Define VDP_VRAM_STATS_EN for cpu_wait_cnt.
module vdp_vram_port
    import vdp_pkg::*;
#(
    parameter int VRAM_SIZE       = VDP_VRAM_SIZE,
    parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE),
    parameter int CPU_Q_DEPTH     = 2
) (
    input  logic                       pxclk,
    input  logic                       reset,
    input  logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr,
    input  logic                       vdp_dma_rd_tick,
    output logic [7:0]                 vram_dout,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr,
    input  logic [7:0]                 cpu_wdata,
    output logic                       cpu_busy,
    output logic                       cpu_ack,
    output logic [7:0]                 cpu_rdata,
    output logic [15:0]                cpu_wait_cnt
);

    localparam int QW = $clog2(CPU_Q_DEPTH);
    localparam int PW = QW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic          dma_pend_q, dma_pend_d;
    logic          ack_q, ack_d;
    logic          rd_pend_q, rd_pend_d;
    logic [7:0]    dout_hold_q, dout_hold_d;
    logic [7:0]    rdata_hold_q, rdata_hold_d;

    cpu_op_t q_mem_q [CPU_Q_DEPTH];
    cpu_op_t q_mem_d [CPU_Q_DEPTH];
    cpu_op_t head;

    logic                       empty;
    logic                       push;
    logic                       pop;
    logic                       ram_en;
    logic                       ram_we;
    logic [VRAM_ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]                 ram_rdata;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = q_mem_q[rd_ptr_q[QW-1:0]];
    assign push  = cpu_req && !full_q;
    assign pop   = !reset && !vdp_dma_rd_tick && !empty;

    assign ram_en   = !reset && (vdp_dma_rd_tick || pop);
    assign ram_we   = pop && head.we;
    assign ram_addr = vdp_dma_rd_tick ? vdp_dma_addr
                                      : VRAM_ADDR_WIDTH'(head.addr);

    // Read data comes straight off the RAM register the cycle after the
    // access; the hold registers keep the outputs stable otherwise.
    assign vram_dout = dma_pend_q ? ram_rdata : dout_hold_q;
    assign cpu_rdata = rd_pend_q ? ram_rdata : rdata_hold_q;
    assign cpu_ack   = ack_q;
    assign cpu_busy  = full_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        q_mem_d      = q_mem_q;
        dma_pend_d   = vdp_dma_rd_tick;
        ack_d        = pop;
        rd_pend_d    = pop && !head.we;
        dout_hold_d  = vram_dout;
        rdata_hold_d = cpu_rdata;
        if (push) begin
            q_mem_d[wr_ptr_q[QW-1:0]] = '{
                we:    cpu_we,
                addr:  VDP_VRAM_AW'(cpu_addr),
                wdata: cpu_wdata
            };
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        full_d = (wr_ptr_d[QW] != rd_ptr_d[QW]) &&
                 (wr_ptr_d[QW-1:0] == rd_ptr_d[QW-1:0]);
    end

    always_ff @(posedge pxclk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            full_q       <= 1'b0;
            dma_pend_q   <= 1'b0;
            ack_q        <= 1'b0;
            rd_pend_q    <= 1'b0;
            dout_hold_q  <= 8'h00;
            rdata_hold_q <= 8'h00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            full_q       <= full_d;
            dma_pend_q   <= dma_pend_d;
            ack_q        <= ack_d;
            rd_pend_q    <= rd_pend_d;
            dout_hold_q  <= dout_hold_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    always_ff @(posedge pxclk) begin
        q_mem_q <= q_mem_d;
    end

`ifdef VDP_VRAM_STATS_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!empty && vdp_dma_rd_tick && wait_cnt_q != 16'hFFFF) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pxclk) begin
        if (reset) begin
            wait_cnt_q <= 16'h0000;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign cpu_wait_cnt = wait_cnt_q;
`else
    assign cpu_wait_cnt = 16'h0000;
`endif

    vdp_vram_ram #(
        .DEPTH (VRAM_SIZE),
        .AW    (VRAM_ADDR_WIDTH)
    ) u_ram (
        .pxclk (pxclk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (cpu_wdata_mux()),
        .rdata (ram_rdata)
    );

    function automatic logic [7:0] cpu_wdata_mux();
        return head.wdata;
    endfunction

endmodule

// File: tb/tb_vdp_vram_port.sv
// Bench for vdp_vram_port: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the port.
module tb_vdp_vram_port;

    localparam int AW    = 13;
    localparam int DEPTH = 2;

    logic          pxclk = 1'b0;
    logic          reset;
    logic [AW-1:0] vdp_dma_addr;
    logic          vdp_dma_rd_tick;
    logic [7:0]    vram_dout;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_busy;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic [15:0]   cpu_wait_cnt;

    int total = 0;
    int bad   = 0;

    always #20 pxclk = ~pxclk;

    vdp_vram_port #(.CPU_Q_DEPTH(DEPTH)) dut (
        .pxclk           (pxclk),
        .reset           (reset),
        .vdp_dma_addr    (vdp_dma_addr),
        .vdp_dma_rd_tick (vdp_dma_rd_tick),
        .vram_dout       (vram_dout),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_busy        (cpu_busy),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .cpu_wait_cnt    (cpu_wait_cnt)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } op_t;

    op_t        q[$];
    logic [7:0] mem [8192];
    bit         mk  [8192];
    logic [7:0] exp_vram;
    bit         exp_vk;
    logic [7:0] exp_rdata;
    bit         exp_rk;
    logic       exp_ack;
    logic       exp_busy;
    logic [15:0] exp_wait;

    // One pxclk: apply inputs, advance the model, land 1 time unit after the edge.
    task automatic cycle(input logic tk, input logic [AW-1:0] da,
                         input logic rq, input logic w,
                         input logic [AW-1:0] a, input logic [7:0] d,
                         input logic rst);
        op_t op;
        bit  was_full;
        reset = rst;
        vdp_dma_rd_tick = tk;
        vdp_dma_addr = da;
        cpu_req = rq;
        cpu_we = w;
        cpu_addr = a;
        cpu_wdata = d;
        if (rst) begin
            q.delete();
            exp_ack = 0; exp_busy = 0; exp_wait = 0;
            exp_vram = 0; exp_vk = 1;
            exp_rdata = 0; exp_rk = 1;
        end else begin
            was_full = (q.size() == DEPTH);
            exp_ack = 0;
            if (tk) begin
                exp_vram = mem[da];
                exp_vk = mk[da];
`ifdef VDP_VRAM_STATS_EN
                if (q.size() > 0 && exp_wait != 16'hFFFF) exp_wait = exp_wait + 1;
`endif
            end else if (q.size() > 0) begin
                op = q.pop_front();
                if (op.we) begin
                    mem[op.a] = op.d;
                    mk[op.a] = 1;
                end else begin
                    exp_rdata = mem[op.a];
                    exp_rk = mk[op.a];
                end
                exp_ack = 1;
            end
            if (rq && !was_full) begin
                op.we = w; op.a = a; op.d = d;
                q.push_back(op);
            end
            exp_busy = (q.size() == DEPTH);
        end
        @(posedge pxclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        total++; if (vram_dout !== 8'h00) begin bad++; $display("FAIL rst_dout got %h want 00", vram_dout); end
        total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got %h want 00", cpu_rdata); end
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got %b want 0", cpu_ack); end
        total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", cpu_busy); end
        total++; if (cpu_wait_cnt !== 16'h0) begin bad++; $display("FAIL rst_wait got %h want 0", cpu_wait_cnt); end
    endtask

    task automatic test_vdp_read;
        cycle(0, 0, 1, 1, 13'h0123, 8'hA5, 0);
        idle(1);
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL preload_ack got %b want 1", cpu_ack); end
        idle(1);
        cycle(1, 13'h0123, 0, 0, 0, 0, 0);
        total++; if (vram_dout !== 8'hA5) begin bad++; $display("FAIL vdp_rd1 got %h want a5", vram_dout); end
        cycle(1, 13'h0123, 0, 0, 0, 0, 0);
        total++; if (vram_dout !== 8'hA5) begin bad++; $display("FAIL vdp_rd2 got %h want a5", vram_dout); end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            total++; if (vram_dout !== 8'hA5) begin bad++; $display("FAIL vdp_hold%0d got %h want a5", i, vram_dout); end
        end
    endtask

    task automatic test_write_read;
        cycle(0, 0, 1, 1, 13'h1FFF, 8'h3C, 0);
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL wr_n1_ack got %b want 0", cpu_ack); end
        cycle(0, 0, 1, 0, 13'h1FFF, 8'h00, 0);
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL wr_n2_ack got %b want 1", cpu_ack); end
        idle(1);
        total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL rd_n3_ack got %b want 1", cpu_ack); end
        total++; if (cpu_rdata !== 8'h3C) begin bad++; $display("FAIL rd_n3_data got %h want 3c", cpu_rdata); end
        idle(1);
        total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_n4_ack got %b want 0", cpu_ack); end
        total++; if (cpu_rdata !== 8'h3C) begin bad++; $display("FAIL rd_hold got %h want 3c", cpu_rdata); end
    endtask

    task automatic test_contention;
        cycle(0, 0, 1, 1, 13'h0456, 8'h5A, 0);
        cycle(0, 0, 1, 1, 13'h1FFF, 8'hC3, 0);
        idle(3);
        cycle(1, 13'h0456, 1, 0, 13'h1FFF, 0, 0);
        total++; if (vram_dout !== 8'h5A) begin bad++; $display("FAIL cont_dout0 got %h want 5a", vram_dout); end
        for (int i = 1; i < 6; i++) begin
            cycle(1, 13'h0456, 0, 0, 0, 0, 0);
            total++; if (cpu_ack !== 1'b0 || vram_dout !== 8'h5A) begin
                bad++; $display("FAIL cont_stall%0d got ack=%b dout=%h want ack=0 dout=5a", i, cpu_ack, vram_dout);
            end
        end
        idle(1);
        total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hC3) begin
            bad++; $display("FAIL cont_ack got ack=%b rdata=%h want ack=1 rdata=c3", cpu_ack, cpu_rdata);
        end
        total++; if (vram_dout !== 8'h5A) begin bad++; $display("FAIL cont_dout got %h want 5a", vram_dout); end
        idle(1);
    endtask

    task automatic test_full;
        int acks;
        cycle(0, 0, 1, 1, 13'h0012, 8'h77, 0);
        idle(3);
        cycle(1, 13'h0456, 1, 1, 13'h0010, 8'h11, 0);
        total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL full_b1 got %b want 0", cpu_busy); end
        cycle(1, 13'h0456, 1, 1, 13'h0011, 8'h22, 0);
        total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL full_b2 got %b want 1", cpu_busy); end
        cycle(1, 13'h0456, 1, 1, 13'h0012, 8'h33, 0);
        total++; if (cpu_busy !== 1'b1) begin bad++; $display("FAIL full_b3 got %b want 1", cpu_busy); end
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1);
            if (cpu_ack === 1'b1) acks++;
        end
        total++; if (acks != 2) begin bad++; $display("FAIL full_acks got %0d want 2", acks); end
        total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL full_release got %b want 0", cpu_busy); end
        cycle(0, 0, 1, 0, 13'h0012, 0, 0);
        idle(2);
        total++; if (cpu_rdata !== 8'h77) begin bad++; $display("FAIL full_dropped got %h want 77", cpu_rdata); end
    endtask

    task automatic test_reset_midop;
        int acks;
        cycle(0, 0, 1, 1, 13'h0020, 8'h01, 0);
        cycle(0, 0, 1, 1, 13'h0021, 8'h02, 0);
        idle(3);
        cycle(1, 13'h0456, 1, 1, 13'h0020, 8'hAA, 0);
        cycle(1, 13'h0456, 1, 1, 13'h0021, 8'hBB, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        total++; if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0 || vram_dout !== 8'h00) begin
            bad++; $display("FAIL rst_mid got ack=%b busy=%b dout=%h want 0 0 00", cpu_ack, cpu_busy, vram_dout);
        end
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (cpu_ack === 1'b1) acks++;
        end
        total++; if (acks != 0) begin bad++; $display("FAIL rst_mid_acks got %0d want 0", acks); end
        cycle(0, 0, 1, 0, 13'h0020, 0, 0);
        cycle(0, 0, 1, 0, 13'h1FFF, 0, 0);
        total++; if (cpu_rdata !== 8'h01) begin bad++; $display("FAIL rst_keep20 got %h want 01", cpu_rdata); end
        idle(1);
        total++; if (cpu_rdata !== 8'hC3) begin bad++; $display("FAIL rst_keep1fff got %h want c3", cpu_rdata); end
        idle(1);
    endtask

    task automatic test_random;
        logic          tk, rq, w;
        logic [AW-1:0] da, a;
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 1, 1, AW'(13'h0040 + i), 8'($urandom), 0);
            idle(1);
        end
        tk = 0; da = 13'h0040;
        for (int i = 0; i < 600; i++) begin
            if (i % 2 == 0) begin
                tk = ($urandom_range(0, 1) == 1);
                da = AW'(13'h0040 + $urandom_range(0, 15));
            end
            rq = ($urandom_range(0, 9) < 6);
            w  = $urandom_range(0, 1) == 1;
            a  = AW'(13'h0040 + $urandom_range(0, 15));
            cycle(tk, da, rq, w, a, 8'($urandom), 0);
            total++; if (cpu_ack !== exp_ack) begin bad++; $display("FAIL rnd_ack@%0d got %b want %b", i, cpu_ack, exp_ack); end
            total++; if (cpu_busy !== exp_busy) begin bad++; $display("FAIL rnd_busy@%0d got %b want %b", i, cpu_busy, exp_busy); end
            total++; if (cpu_wait_cnt !== exp_wait) begin bad++; $display("FAIL rnd_wait@%0d got %h want %h", i, cpu_wait_cnt, exp_wait); end
            if (exp_rk) begin
                total++; if (cpu_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata@%0d got %h want %h", i, cpu_rdata, exp_rdata); end
            end
            if (exp_vk) begin
                total++; if (vram_dout !== exp_vram) begin bad++; $display("FAIL rnd_dout@%0d got %h want %h", i, vram_dout, exp_vram); end
            end
        end
        idle(4);
    endtask

    task automatic test_stats;
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(1, 13'h0040, 1, 0, 13'h0041, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 13'h0040, 0, 0, 0, 0, 0);
        idle(3);
`ifdef VDP_VRAM_STATS_EN
        total++; if (cpu_wait_cnt !== 16'd5) begin bad++; $display("FAIL stats5 got %0d want 5", cpu_wait_cnt); end
        cycle(1, 13'h0040, 1, 0, 13'h0041, 0, 0);
        for (int i = 0; i < 70000; i++) cycle(1, 13'h0040, 0, 0, 0, 0, 0);
        idle(3);
        total++; if (cpu_wait_cnt !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got %h want ffff", cpu_wait_cnt); end
`else
        total++; if (cpu_wait_cnt !== 16'h0000) begin bad++; $display("FAIL stats_off got %h want 0000", cpu_wait_cnt); end
`endif
        total++; if (cpu_wait_cnt !== exp_wait) begin bad++; $display("FAIL stats_model got %h want %h", cpu_wait_cnt, exp_wait); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i] = 8'h00;
            mk[i] = 0;
        end
        reset = 1; vdp_dma_rd_tick = 0; vdp_dma_addr = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        test_reset();
        test_vdp_read();
        test_write_read();
        test_contention();
        test_full();
        test_reset_midop();
        test_random();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
